// File: rtl/clk_period_monitor.sv
// Slow-clock period monitor: syncs ClkIn, measures rise-to-rise period, reports lock/stall.
// Ports: Clk, Rst (async active-low), ClkIn -> Tick, Period, PeriodValid, InRange, Locked, Stall, HighTime.
// Optional macro CLK_MON_HIGHTIME_EN builds the high-phase counter; otherwise HighTime is 0.
module clk_period_monitor #(
    parameter int          CNT_W   = 27,
    parameter int unsigned EXP_PER = 100000002,
    parameter int unsigned TOL     = 1000,
    parameter int unsigned LOCK_N  = 4,
    parameter int unsigned TIMEOUT = 120000000
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ClkIn,
    output logic             Tick,
    output logic [CNT_W-1:0] Period,
    output logic             PeriodValid,
    output logic             InRange,
    output logic             Locked,
    output logic             Stall,
    output logic [CNT_W-1:0] HighTime
);

    // Lower bound clamps at zero when the tolerance exceeds the target.
    localparam int unsigned      LO    = (EXP_PER > TOL) ? EXP_PER - TOL : 0;
    localparam int unsigned      HI    = EXP_PER + TOL;
    localparam logic [CNT_W-1:0] TO    = CNT_W'(TIMEOUT);
    localparam logic [3:0]       RUN_N = 4'(LOCK_N);

    typedef enum logic [1:0] {
        WAIT_FIRST,
        MEASURE,
        LOCKED,
        STALLED
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   meas;
    logic             in_rng;
    logic             timeout;
    logic [3:0]       run;
    logic [3:0]       run_nxt;
    logic             upd;

    assign rise    = s2 & ~s3;
    // One extra bit so a saturated counter cannot wrap the measurement.
    assign meas    = {1'b0, cnt} + (CNT_W + 1)'(1);
    assign in_rng  = (32'(meas) >= LO) && (32'(meas) <= HI);
    assign timeout = (cnt == TO);
    assign Locked  = (state == LOCKED);
    assign Stall   = (state == STALLED);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= ClkIn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        upd       = 1'b0;
        unique case (state)
            WAIT_FIRST: begin
                if (rise) begin
                    state_nxt = MEASURE;
                end else if (timeout) begin
                    state_nxt = STALLED;
                end
            end
            MEASURE: begin
                if (rise) begin
                    upd = 1'b1;
                    if (in_rng) begin
                        if (run < RUN_N) begin
                            run_nxt = run + 4'd1;
                        end
                        if (run_nxt == RUN_N) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        run_nxt = '0;
                    end
                end else if (timeout) begin
                    state_nxt = STALLED;
                    run_nxt   = '0;
                end
            end
            LOCKED: begin
                if (rise) begin
                    upd = 1'b1;
                    if (!in_rng) begin
                        state_nxt = MEASURE;
                        run_nxt   = '0;
                    end
                end else if (timeout) begin
                    state_nxt = STALLED;
                    run_nxt   = '0;
                end
            end
            STALLED: begin
                // The resuming edge only re-arms; it has no valid reference.
                if (rise) begin
                    state_nxt = MEASURE;
                end
            end
            default: state_nxt = WAIT_FIRST;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= WAIT_FIRST;
            run   <= '0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Tick        <= 1'b0;
            PeriodValid <= 1'b0;
            Period      <= '0;
            InRange     <= 1'b0;
        end else begin
            Tick        <= rise;
            PeriodValid <= upd;
            if (upd) begin
                Period  <= meas[CNT_W-1:0];
                InRange <= in_rng;
            end
        end
    end

`ifdef CLK_MON_HIGHTIME_EN
    logic             fall;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hpend;

    assign fall = ~s2 & s3;

    // High count is parked at the fall and published with the next period.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hcnt     <= '0;
            hpend    <= '0;
            HighTime <= '0;
        end else begin
            if (rise) begin
                hcnt <= CNT_W'(1);
            end else if (s2 && hcnt != '1) begin
                hcnt <= hcnt + CNT_W'(1);
            end
            if (fall) begin
                hpend <= hcnt;
            end
            if (upd) begin
                HighTime <= hpend;
            end
        end
    end
`else
    assign HighTime = '0;
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed scoreboard bench for clk_period_monitor.
// Expected periods are queued as ClkIn is driven and checked at each PeriodValid.
module tb_clk_period_monitor;

    logic       Clk;
    logic       Rst;
    logic       ClkIn;
    logic       Tick;
    logic [7:0] Period;
    logic       PeriodValid;
    logic       InRange;
    logic       Locked;
    logic       Stall;
    logic [7:0] HighTime;

    typedef struct {
        int per;
        int inr;
        int lck;
        int ht;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    clk_period_monitor #(
        .CNT_W  (8),
        .EXP_PER(10),
        .TOL    (1),
        .LOCK_N (3),
        .TIMEOUT(40)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .ClkIn      (ClkIn),
        .Tick       (Tick),
        .Period     (Period),
        .PeriodValid(PeriodValid),
        .InRange    (InRange),
        .Locked     (Locked),
        .Stall      (Stall),
        .HighTime   (HighTime)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int eh(input int h);
`ifdef CLK_MON_HIGHTIME_EN
        return h;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic push(input int per, input int inr, input int lck,
                        input int ht);
        exp_t e;
        e.per = per;
        e.inr = inr;
        e.lck = lck;
        e.ht  = eh(ht);
        q.push_back(e);
    endtask

    // Entered and left at posedge+2; rises are hi+lo Clk cycles apart.
    task automatic cyc(input int hi, input int lo);
        ClkIn = 1'b1;
        repeat (hi) @(posedge Clk);
        #2 ClkIn = 1'b0;
        repeat (lo) @(posedge Clk);
        #2;
    endtask

    always @(negedge Clk) begin
        if (PeriodValid === 1'b1) begin
            if (q.size() == 0) begin
                chk("pv_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("period", 32'(Period), 32'(e.per));
                chk("in_range", 32'(InRange), 32'(e.inr));
                chk("locked", 32'(Locked), 32'(e.lck));
                chk("high_time", 32'(HighTime), 32'(e.ht));
                chk("stall_at_pv", 32'(Stall), 32'd0);
            end
        end
    end

    initial begin
        Rst   = 1'b0;
        ClkIn = 1'b0;
        #1;
        chk("rst_tick", 32'(Tick), 32'd0);
        chk("rst_period", 32'(Period), 32'd0);
        chk("rst_pv", 32'(PeriodValid), 32'd0);
        chk("rst_inrange", 32'(InRange), 32'd0);
        chk("rst_locked", 32'(Locked), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_hightime", 32'(HighTime), 32'd0);
        repeat (3) @(posedge Clk);
        #2 Rst = 1'b1;
        repeat (3) @(posedge Clk);
        #2;

        // Lock on period 10, then one out-of-range 13, relock on 9.
        cyc(5, 5);
        push(10, 1, 0, 5); cyc(5, 5);
        push(10, 1, 0, 5); cyc(5, 5);
        push(10, 1, 1, 5); cyc(5, 8);
        push(13, 0, 0, 5); cyc(5, 4);
        push(9, 1, 0, 5);  cyc(5, 4);
        push(9, 1, 0, 5);  cyc(5, 4);
        push(9, 1, 1, 5);

        // Final rise, then hold low until the stall fires.
        ClkIn = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("tick_latency", 32'(Tick), 32'd1);
        chk("locked_before_stall", 32'(Locked), 32'd1);
        @(negedge Clk);
        chk("tick_one_cycle", 32'(Tick), 32'd0);
        ClkIn = 1'b0;
        repeat (39) @(negedge Clk);
        chk("stall_early", 32'(Stall), 32'd0);
        chk("locked_early", 32'(Locked), 32'd1);
        @(negedge Clk);
        chk("stall_at_41", 32'(Stall), 32'd1);
        chk("locked_at_41", 32'(Locked), 32'd0);

        // Resume: first edge only re-arms.
        @(posedge Clk);
        #2;
        cyc(5, 5);
        chk("stall_cleared", 32'(Stall), 32'd0);
        push(10, 1, 0, 5); cyc(5, 5);
        push(10, 1, 0, 5); cyc(5, 5);

        // Asynchronous reset mid-period.
        repeat (4) @(posedge Clk);
        #3 Rst = 1'b0;
        #1;
        chk("mid_rst_period", 32'(Period), 32'd0);
        chk("mid_rst_inrange", 32'(InRange), 32'd0);
        chk("mid_rst_pv", 32'(PeriodValid), 32'd0);
        chk("mid_rst_tick", 32'(Tick), 32'd0);
        chk("mid_rst_locked", 32'(Locked), 32'd0);
        chk("mid_rst_stall", 32'(Stall), 32'd0);
        chk("mid_rst_hightime", 32'(HighTime), 32'd0);
        repeat (3) @(posedge Clk);
        #2 Rst = 1'b1;
        repeat (3) @(posedge Clk);
        #2;

        // First edge after reset, then an edge exactly at cnt==TIMEOUT.
        cyc(5, 5);
        push(10, 1, 0, 5); cyc(5, 36);
        push(41, 0, 0, 5); cyc(5, 5);
        chk("stall_edge_wins", 32'(Stall), 32'd0);

        // 3-high / 7-low shape, relock.
        push(10, 1, 0, 5); cyc(3, 7);
        push(10, 1, 0, 3); cyc(3, 7);
        push(10, 1, 1, 3); cyc(5, 5);

        repeat (3) @(negedge Clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("final_locked", 32'(Locked), 32'd1);
        chk("final_stall", 32'(Stall), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
